// File: rtl/clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// clk_rst_sequencer
//
// Purpose:
//   Turns one system clock into the core reset release, NUM_CH programmable
//   divided-clock channels (each giving a one-cycle tick and a 50% phase
//   square wave) and a run-length timeout. FPGA and simulation builds share
//   this sequencing.
//
//   State machine: HOLD (core held in reset) -> RUN -> DONE (sticky until reset).
//
// Ports:
//   clk           in   system clock, all logic on the rising edge
//   reset         in   synchronous active-high reset
//   div_cfg       in   per-channel divisors, channel i at [i*DIV_W +: DIV_W]
//   cfg_load      in   one-cycle strobe that latches div_cfg and restarts all
//                      channel counters (ignored in DONE)
//   ch_en         in   per-channel run enable
//   timeout_limit in   number of RUN cycles before DONE; 0 disables the timeout
//   core_reset    out  active-high reset to the core and peripherals
//   tick          out  per-channel one-cycle pulse, once per divisor period
//   phase         out  per-channel square wave, toggles on every tick
//   cycle_count   out  RUN cycles elapsed; saturates at all-ones
//   timeout       out  sticky flag, high in DONE
// -----------------------------------------------------------------------------
module clk_rst_sequencer #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned RST_HOLD    = 8,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [CNT_W-1:0]        timeout_limit,
  output logic                    core_reset,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       phase,
  output logic [CNT_W-1:0]        cycle_count,
  output logic                    timeout
);

  // The hold counter only has to reach RST_HOLD-1.
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [HOLD_W-1:0]               hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]                cyc_q, cyc_d;
  logic [CNT_W-1:0]                cyc_inc_s;
  logic                            core_reset_q, core_reset_d;
  logic                            timeout_q, timeout_d;
  logic [NUM_CH-1:0][DIV_W-1:0]    div_q, div_d;
  logic [NUM_CH-1:0][DIV_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]               tick_q, tick_d;
  logic [NUM_CH-1:0]               phase_q, phase_d;
  logic [NUM_CH-1:0]               active_s;
  logic [NUM_CH-1:0]               wrap_s;
  logic                            run_s;
  logic                            load_s;

  // Sequencer FSM: hold countdown, RUN cycle counting and timeout detection.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cyc_d      = cyc_q;
    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    if (cyc_q == {CNT_W{1'b1}}) begin
      cyc_inc_s = cyc_q;
    end else begin
      cyc_inc_s = cyc_q + CNT_W'(1);
    end
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = {HOLD_W{1'b0}};
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        cyc_d = cyc_inc_s;
        // Compare against the post-increment value with >= so that lowering
        // the limit below the current count ends the run on the next cycle.
        if ((timeout_limit != {CNT_W{1'b0}}) && (cyc_inc_s >= timeout_limit)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        // Unreachable encoding: fall back to holding the core in reset.
        state_d    = ST_HOLD;
        hold_cnt_d = {HOLD_W{1'b0}};
      end
    endcase
    core_reset_d = (state_d == ST_HOLD);
    timeout_d    = (state_d == ST_DONE);
  end

  // Divider channels: divisor load, period counters, tick and phase generation.
  always_comb begin
    run_s  = (state_q == ST_RUN);
    load_s = cfg_load && (state_q != ST_DONE);
    div_d    = div_q;
    cnt_d    = cnt_q;
    tick_d   = {NUM_CH{1'b0}};
    phase_d  = phase_q;
    active_s = {NUM_CH{1'b0}};
    wrap_s   = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_s) begin
        div_d[i] = div_cfg[i*DIV_W +: DIV_W];
      end else begin
        div_d[i] = div_q[i];
      end
      // A zero divisor halts the channel, so D-1 is only meaningful when active.
      active_s[i] = run_s && ch_en[i] && (div_q[i] != {DIV_W{1'b0}});
      wrap_s[i]   = active_s[i] && (cnt_q[i] == (div_q[i] - DIV_W'(1)));
      // The load clears counters, but the wrap computed from the old divisor
      // still produces its tick and phase toggle at the same edge.
      if (load_s) begin
        cnt_d[i] = {DIV_W{1'b0}};
      end else if (wrap_s[i]) begin
        cnt_d[i] = {DIV_W{1'b0}};
      end else if (active_s[i]) begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      // Ticks are suppressed from the cycle DONE is entered onwards.
      tick_d[i]  = wrap_s[i] && (state_d != ST_DONE);
      phase_d[i] = phase_q[i] ^ wrap_s[i];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= {HOLD_W{1'b0}};
      cyc_q        <= {CNT_W{1'b0}};
      core_reset_q <= 1'b1;
      timeout_q    <= 1'b0;
      div_q        <= {NUM_CH{DIV_RST}};
      cnt_q        <= {(NUM_CH*DIV_W){1'b0}};
      tick_q       <= {NUM_CH{1'b0}};
      phase_q      <= {NUM_CH{1'b0}};
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cyc_q        <= cyc_d;
      core_reset_q <= core_reset_d;
      timeout_q    <= timeout_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      phase_q      <= phase_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign tick        = tick_q;
  assign phase       = phase_q;
  assign cycle_count = cyc_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clk_rst_sequencer
//
// Self-checking bench for clk_rst_sequencer. Each scenario task drives the
// stimulus for one edge, pushes the expected output word for that edge onto a
// scoreboard queue, advances one clock and pops/compares against the DUT.
// Output word layout: {core_reset, timeout, tick[1:0], phase[1:0], cycle_count}.
// -----------------------------------------------------------------------------
module tb_clk_rst_sequencer;

  localparam int unsigned NUM_CH      = 2;
  localparam int unsigned DIV_W       = 16;
  localparam int unsigned RST_HOLD    = 8;
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned DEFAULT_DIV = 1;

  typedef logic [37:0] obs_t;
  typedef struct {
    obs_t val;
    obs_t mask;
  } exp_t;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH*DIV_W-1:0] div_cfg;
  logic                    cfg_load;
  logic [NUM_CH-1:0]       ch_en;
  logic [CNT_W-1:0]        timeout_limit;
  logic                    core_reset;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       phase;
  logic [CNT_W-1:0]        cycle_count;
  logic                    timeout;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  obs_t obs_s;
  obs_t full_mask;
  obs_t no_phase_mask;

  assign obs_s = {core_reset, timeout, tick, phase, cycle_count};

  clk_rst_sequencer #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .RST_HOLD    (RST_HOLD),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .div_cfg       (div_cfg),
    .cfg_load      (cfg_load),
    .ch_en         (ch_en),
    .timeout_limit (timeout_limit),
    .core_reset    (core_reset),
    .tick          (tick),
    .phase         (phase),
    .cycle_count   (cycle_count),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic cr, input logic to, input logic [1:0] tk,
                              input logic [1:0] ph, input int cc);
    return {cr, to, tk, ph, 32'(cc)};
  endfunction

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, load divisors at edge 1 with channels disabled, arrive just after
  // edge 8 (RUN entered, counters 0, phases 0), then apply the channel enables.
  task automatic bring_up(input logic [31:0] divs, input logic [1:0] en, input int lim);
    reset = 1'b1; cfg_load = 1'b0; ch_en = 2'b00;
    timeout_limit = 32'(lim); div_cfg = divs;
    step();
    reset = 1'b0; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    repeat (7) step();
    ch_en = en;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; cfg_load = 1'b0; ch_en = 2'b11; div_cfg = 32'h0;
    timeout_limit = 32'd0;
    for (int k = 1; k <= 2; k++) begin
      sb_q.push_back('{mk(1'b1, 1'b0, 2'b00, 2'b00, 0), full_mask});
      step();
      e = sb_q.pop_front();
      checks++;
      if ((obs_s & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL reset edge=%0d got=%h expected=%h", k, obs_s & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_release();
    exp_t       e;
    logic [1:0] et;
    logic [1:0] ep;
    reset = 1'b1; cfg_load = 1'b0; ch_en = 2'b11; timeout_limit = 32'd0;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      et = (k >= 9) ? 2'b11 : 2'b00;
      ep = (k >= 9 && ((k - 8) % 2 == 1)) ? 2'b11 : 2'b00;
      sb_q.push_back('{mk(k < 8, 1'b0, et, ep, (k >= 9) ? k - 8 : 0), full_mask});
      step();
      e = sb_q.pop_front();
      checks++;
      if ((obs_s & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL release edge=%0d got=%h expected=%h", k, obs_s & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_cfg_load();
    exp_t       e;
    logic [1:0] et;
    logic [1:0] ep;
    int         m;
    bring_up({16'd1, 16'd1}, 2'b11, 0);
    ep = 2'b00;
    for (int n = 1; n <= 44; n++) begin
      cfg_load = (n == 4);
      div_cfg  = {16'd5, 16'd10};
      if (n <= 4) begin
        et = 2'b11;
      end else begin
        m  = n - 4;
        et = {(m % 5 == 0), (m % 10 == 0)};
      end
      ep = ep ^ et;
      sb_q.push_back('{mk(1'b0, 1'b0, et, ep, n), full_mask});
      step();
      cfg_load = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if ((obs_s & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL cfg_load n=%0d got=%h expected=%h", n, obs_s & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_halt();
    exp_t       e;
    logic [1:0] et;
    logic [1:0] ep;
    bring_up({16'd0, 16'd4}, 2'b11, 0);
    ep = 2'b00;
    for (int n = 1; n <= 24; n++) begin
      ch_en = {1'b1, !(n >= 6 && n <= 8)};
      // Without the 3-cycle stall ch0 would tick at 4,8,12...; with it 4,11,15...
      et = {1'b0, (n == 4) || (n >= 11 && ((n - 11) % 4 == 0))};
      ep = ep ^ et;
      sb_q.push_back('{mk(1'b0, 1'b0, et, ep, n), full_mask});
      step();
      e = sb_q.pop_front();
      checks++;
      if ((obs_s & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL halt n=%0d got=%h expected=%h", n, obs_s & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t       e;
    logic [1:0] et;
    logic [1:0] ep;
    bring_up({16'd2, 16'd3}, 2'b11, 100);
    ep = 2'b00;
    for (int n = 1; n <= 116; n++) begin
      // Edge 111 carries a cfg_load that must be ignored in DONE.
      cfg_load = (n == 111);
      div_cfg  = {16'd1, 16'd1};
      if (n < 100) begin
        et = {(n % 2 == 0), (n % 3 == 0)};
        ep = ep ^ et;
        sb_q.push_back('{mk(1'b0, 1'b0, et, ep, n), full_mask});
      end else begin
        sb_q.push_back('{mk(1'b0, 1'b1, 2'b00, 2'b00, 100), no_phase_mask});
      end
      step();
      cfg_load = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if ((obs_s & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL timeout n=%0d got=%h expected=%h", n, obs_s & e.mask, e.val & e.mask);
      end
    end
    timeout_limit = 32'd0;
  endtask

  task automatic test_mid_reset();
    exp_t       e;
    logic [1:0] et;
    logic [1:0] ep;
    // ch0 D=3 gives 19 ticks by n=57, ch1 D=1 gives 57: both phases end at 1.
    bring_up({16'd1, 16'd3}, 2'b11, 0);
    ep = 2'b00;
    for (int n = 1; n <= 57; n++) begin
      et = {1'b1, (n % 3 == 0)};
      ep = ep ^ et;
      sb_q.push_back('{mk(1'b0, 1'b0, et, ep, n), full_mask});
      step();
      e = sb_q.pop_front();
      checks++;
      if ((obs_s & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL mid_reset run n=%0d got=%h expected=%h", n, obs_s & e.mask, e.val & e.mask);
      end
    end
    reset = 1'b1;
    sb_q.push_back('{mk(1'b1, 1'b0, 2'b00, 2'b00, 0), full_mask});
    step();
    reset = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if ((obs_s & e.mask) !== (e.val & e.mask)) begin
      errors++;
      $display("FAIL mid_reset pulse got=%h expected=%h", obs_s & e.mask, e.val & e.mask);
    end
    // Divisors are back at DEFAULT_DIV=1, so the release sequence repeats.
    for (int k = 1; k <= 12; k++) begin
      et = (k >= 9) ? 2'b11 : 2'b00;
      ep = (k >= 9 && ((k - 8) % 2 == 1)) ? 2'b11 : 2'b00;
      sb_q.push_back('{mk(k < 8, 1'b0, et, ep, (k >= 9) ? k - 8 : 0), full_mask});
      step();
      e = sb_q.pop_front();
      checks++;
      if ((obs_s & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL mid_reset hold edge=%0d got=%h expected=%h", k, obs_s & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [1:0] et;
    logic [1:0] ep;
    logic       t;
    bring_up({16'd3, 16'd3}, 2'b11, 0);
    ep = 2'b00;
    for (int n = 1; n <= 20; n++) begin
      // The load lands on the D=3 tick edge n=6; the next tick is 6 later.
      cfg_load = (n == 6);
      div_cfg  = {16'd6, 16'd6};
      t  = (n <= 6) ? (n % 3 == 0) : ((n - 6) % 6 == 0);
      et = {t, t};
      ep = ep ^ et;
      sb_q.push_back('{mk(1'b0, 1'b0, et, ep, n), full_mask});
      step();
      cfg_load = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if ((obs_s & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL back_to_back n=%0d got=%h expected=%h", n, obs_s & e.mask, e.val & e.mask);
      end
    end
  endtask

  initial begin
    full_mask            = {38{1'b1}};
    no_phase_mask        = {38{1'b1}};
    no_phase_mask[33:32] = 2'b00;
    reset         = 1'b1;
    cfg_load      = 1'b0;
    ch_en         = 2'b00;
    div_cfg       = 32'h0;
    timeout_limit = 32'd0;
    test_reset();
    test_release();
    test_cfg_load();
    test_halt();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
